// File: rtl/nlfsr_pkg.sv
// rtl/nlfsr_pkg.sv - shared state type, tap-byte constants and tap validity check
package nlfsr_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD_CFG = 2'd1,
      WARMUP   = 2'd2,
      RUN      = 2'd3
   } state_t;

   localparam int TAP_BYTE_W  = 8;
   localparam int TAP_IDX_MIN = 1;

   // A tap index must address a real register bit: 1 .. size-1.
   function automatic logic tap_byte_bad(input logic [TAP_BYTE_W-1:0] b, input int size);
      return (int'(b) < TAP_IDX_MIN) || (int'(b) >= size);
   endfunction

endpackage

// File: rtl/nlfsr_tap_loader.sv
// rtl/nlfsr_tap_loader.sv - assembles tap index bytes into co_buf, flags bad indices
module nlfsr_tap_loader
   import nlfsr_pkg::*;
#(
   parameter int NUM_OF_TAPS = 15,
   parameter int SIZE        = 32
) (
   input  logic                              clk,
   input  logic                              res,
   input  logic                              i_begin,
   input  logic                              i_active,
   input  logic                              i_valid,
   input  logic [TAP_BYTE_W-1:0]             i_data,
   output logic [NUM_OF_TAPS*TAP_BYTE_W-1:0] o_co_buf,
   output logic                              o_cfg_err,
   output logic                              o_cfg_loaded,
   output logic                              o_last
);

   localparam int K_W = $clog2(NUM_OF_TAPS + 1);

   logic [K_W-1:0]                    r_k;
   logic [NUM_OF_TAPS*TAP_BYTE_W-1:0] r_co_buf;
   logic                              r_cfg_err;
   logic                              r_cfg_loaded;
   logic                              w_accept;

   assign w_accept     = i_active & i_valid;
   assign o_last       = w_accept & (r_k == K_W'(NUM_OF_TAPS - 1));
   assign o_co_buf     = r_co_buf;
   assign o_cfg_err    = r_cfg_err;
   assign o_cfg_loaded = r_cfg_loaded;

   always_ff @(posedge clk) begin
      if (res) begin
         r_k          <= '0;
         r_co_buf     <= '0;
         r_cfg_err    <= 1'b0;
         r_cfg_loaded <= 1'b0;
      end else if (i_begin) begin
         r_k          <= '0;
         r_cfg_err    <= 1'b0;
         r_cfg_loaded <= 1'b0;
      end else if (w_accept) begin
         for (int i = 0; i < NUM_OF_TAPS; i++) begin
            if (r_k == K_W'(i)) r_co_buf[i*TAP_BYTE_W +: TAP_BYTE_W] <= i_data;
         end
         r_k <= r_k + K_W'(1);
         if (tap_byte_bad(i_data, SIZE)) r_cfg_err <= 1'b1;
         if (o_last) r_cfg_loaded <= 1'b1;
      end
   end

endmodule

// File: rtl/nlfsr_seq_ctrl.sv
// rtl/nlfsr_seq_ctrl.sv - NLFSR sequencer: tap load, seeding, warm-up and keystream output
module nlfsr_seq_ctrl
   import nlfsr_pkg::*;
#(
   parameter int NUM_OF_TAPS = 15,
   parameter int SIZE        = 32,
   parameter int WARM_W      = 16
) (
   input  logic                              clk,
   input  logic                              res,
   input  logic                              load_cfg,
   input  logic                              cfg_valid,
   input  logic [7:0]                        cfg_data,
   output logic                              cfg_ready,
   input  logic                              seed_valid,
   input  logic [SIZE-1:0]                   seed,
   input  logic                              start,
   input  logic                              stop,
   input  logic [WARM_W-1:0]                 warmup,
   input  logic                              feedback,
   output logic [NUM_OF_TAPS*8-1:0]          co_buf,
   output logic [SIZE-1:0]                   register,
   output logic                              taps_en,
   output logic                              out_valid,
   output logic                              out_bit,
   input  logic                              out_ready,
   output logic                              busy,
   output logic                              cfg_err,
   output logic                              seed_err,
   output logic                              ready_to_run
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [SIZE-1:0]   r_register;
   logic [WARM_W-1:0] r_count;
   logic              r_seeded;
   logic              r_seed_err;
   logic              w_cfg_loaded;
   logic              w_last;
   logic              w_idle;
   logic              w_idle_load;
   logic              w_idle_seed;
   logic              w_idle_start;
   logic              w_shift;

   nlfsr_tap_loader #(
      .NUM_OF_TAPS (NUM_OF_TAPS),
      .SIZE        (SIZE)
   ) u_loader (
      .clk          (clk),
      .res          (res),
      .i_begin      (w_idle_load),
      .i_active     (r_state == LOAD_CFG),
      .i_valid      (cfg_valid),
      .i_data       (cfg_data),
      .o_co_buf     (co_buf),
      .o_cfg_err    (cfg_err),
      .o_cfg_loaded (w_cfg_loaded),
      .o_last       (w_last)
   );

   // IDLE arbitration: load_cfg beats seed_valid beats start.
   assign w_idle       = (r_state == IDLE);
   assign w_idle_load  = w_idle & load_cfg;
   assign w_idle_seed  = w_idle & ~load_cfg & seed_valid;
   assign w_idle_start = w_idle & ~load_cfg & ~seed_valid & start & ready_to_run;
   assign w_shift      = ~stop & ((r_state == WARMUP) | ((r_state == RUN) & out_ready));

   assign ready_to_run = w_cfg_loaded & ~cfg_err & r_seeded;
   assign register     = r_register;
   assign out_bit      = r_register[0];
   assign seed_err     = r_seed_err;

   always_comb begin
      w_state_nxt = r_state;
      cfg_ready   = 1'b0;
      taps_en     = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (w_idle_load)       w_state_nxt = LOAD_CFG;
            else if (w_idle_start) w_state_nxt = (warmup != '0) ? WARMUP : RUN;
         end
         LOAD_CFG: begin
            cfg_ready = 1'b1;
            if (w_last) w_state_nxt = IDLE;
         end
         WARMUP: begin
            taps_en = 1'b1;
            if (stop)                            w_state_nxt = IDLE;
            else if (r_count == WARM_W'(1))      w_state_nxt = RUN;
         end
         RUN: begin
            taps_en   = 1'b1;
            out_valid = 1'b1;
            if (stop) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         r_state    <= IDLE;
         r_register <= '0;
         r_count    <= '0;
         r_seeded   <= 1'b0;
         r_seed_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_idle_seed) begin
            // A zero seed would lock the NLFSR; keep the old state and flag it.
            if (seed != '0) begin
               r_register <= seed;
               r_seeded   <= 1'b1;
               r_seed_err <= 1'b0;
            end else begin
               r_seeded   <= 1'b0;
               r_seed_err <= 1'b1;
            end
         end else if (w_shift) begin
            r_register <= {feedback, r_register[SIZE-1:1]};
         end
         if (w_idle_start)                      r_count <= warmup;
         else if ((r_state == WARMUP) && !stop) r_count <= r_count - WARM_W'(1);
      end
   end

endmodule

// File: tb/tb_nlfsr_seq_ctrl.sv
// tb/tb_nlfsr_seq_ctrl.sv - directed and randomized checks of nlfsr_seq_ctrl against a behavioural model
module tb_nlfsr_seq_ctrl;

   localparam int NT = 15;
   localparam int SZ = 32;
   localparam int WW = 16;

   logic              clk = 1'b0;
   logic              res = 1'b1;
   logic              load_cfg = 1'b0;
   logic              cfg_valid = 1'b0;
   logic [7:0]        cfg_data = '0;
   logic              seed_valid = 1'b0;
   logic [SZ-1:0]     seed = '0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [WW-1:0]     warmup = '0;
   logic              feedback = 1'b0;
   logic              out_ready = 1'b0;
   logic              cfg_ready;
   logic [NT*8-1:0]   co_buf;
   logic [SZ-1:0]     register;
   logic              taps_en;
   logic              out_valid;
   logic              out_bit;
   logic              busy;
   logic              cfg_err;
   logic              seed_err;
   logic              ready_to_run;

   nlfsr_seq_ctrl #(.NUM_OF_TAPS(NT), .SIZE(SZ), .WARM_W(WW)) dut (
      .clk          (clk),
      .res          (res),
      .load_cfg     (load_cfg),
      .cfg_valid    (cfg_valid),
      .cfg_data     (cfg_data),
      .cfg_ready    (cfg_ready),
      .seed_valid   (seed_valid),
      .seed         (seed),
      .start        (start),
      .stop         (stop),
      .warmup       (warmup),
      .feedback     (feedback),
      .co_buf       (co_buf),
      .register     (register),
      .taps_en      (taps_en),
      .out_valid    (out_valid),
      .out_bit      (out_bit),
      .out_ready    (out_ready),
      .busy         (busy),
      .cfg_err      (cfg_err),
      .seed_err     (seed_err),
      .ready_to_run (ready_to_run)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: what the sequencer should hold after each operation.
   logic [NT*8-1:0] m_cobuf;
   logic [SZ-1:0]   m_reg;
   bit              m_loaded, m_cfg_err, m_seeded, m_seed_err;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SZ-1:0] shifted(input logic [SZ-1:0] r, input bit fb);
      return (r >> 1) + (fb ? (SZ'(1) << (SZ - 1)) : '0);
   endfunction

   task automatic chk_static(input string tag);
      chk({tag, "_co_buf"}, co_buf, m_cobuf);
      chk({tag, "_register"}, register, m_reg);
      chk({tag, "_cfg_err"}, cfg_err, m_cfg_err);
      chk({tag, "_seed_err"}, seed_err, m_seed_err);
      chk({tag, "_rtr"}, ready_to_run, m_loaded & ~m_cfg_err & m_seeded);
   endtask

   task automatic do_reset(input string tag);
      res = 1'b1;
      tick();
      res = 1'b0;
      m_cobuf = '0; m_reg = '0;
      m_loaded = 0; m_cfg_err = 0; m_seeded = 0; m_seed_err = 0;
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cfg_ready"}, cfg_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_taps_en"}, taps_en, 0);
      chk_static(tag);
   endtask

   task automatic load_table(input logic [7:0] t [NT], input int max_gap, input bit noise);
      load_cfg = 1'b1;
      if (noise) begin
         seed_valid = 1'b1;
         seed       = $urandom | 32'h1;
         start      = 1'b1;
      end
      tick();
      load_cfg = 1'b0; seed_valid = 1'b0; start = 1'b0;
      m_loaded = 0; m_cfg_err = 0;
      chk("load_busy", busy, 1);
      chk("load_reg_kept", register, m_reg);
      for (int i = 0; i < NT; i++) begin
         repeat ($urandom_range(max_gap)) begin
            cfg_valid = 1'b0;
            stop  = 1'($urandom);
            start = 1'($urandom);
            tick();
         end
         stop = 1'b0; start = 1'b0;
         chk("load_cfg_ready", cfg_ready, 1);
         cfg_valid = 1'b1;
         cfg_data  = t[i];
         tick();
         m_cobuf[i*8 +: 8] = t[i];
         if (t[i] == 8'd0 || int'(t[i]) >= SZ) m_cfg_err = 1;
      end
      cfg_valid = 1'b0;
      m_loaded  = 1;
      chk("load_done_ready", cfg_ready, 0);
      chk("load_done_busy", busy, 0);
      chk_static("load_done");
   endtask

   task automatic do_seed(input logic [SZ-1:0] s);
      seed_valid = 1'b1;
      seed       = s;
      tick();
      seed_valid = 1'b0;
      if (s != '0) begin
         m_reg = s; m_seeded = 1; m_seed_err = 0;
      end else begin
         m_seeded = 0; m_seed_err = 1;
      end
      chk_static("seed");
   endtask

   // fb_mode < 0 drives random feedback, otherwise the given constant
   task automatic start_run(input int w, input int fb_mode);
      bit fb;
      warmup = WW'(w);
      start  = 1'b1;
      tick();
      start = 1'b0;
      if (!(m_loaded && !m_cfg_err && m_seeded)) begin
         chk("start_ignored_busy", busy, 0);
         chk("start_ignored_reg", register, m_reg);
         return;
      end
      for (int c = 0; c < w; c++) begin
         chk("warm_out_valid", out_valid, 0);
         chk("warm_taps_en", taps_en, 1);
         fb = (fb_mode < 0) ? 1'($urandom) : 1'(fb_mode);
         feedback = fb;
         tick();
         m_reg = shifted(m_reg, fb);
      end
      chk("first_out_valid", out_valid, 1);
      chk("first_reg", register, m_reg);
   endtask

   task automatic stream(input int n, input int fb_mode, input int rdy_mode);
      bit fb, rdy;
      for (int c = 0; c < n; c++) begin
         chk("run_out_valid", out_valid, 1);
         chk("run_out_bit", out_bit, m_reg[0]);
         chk("run_register", register, m_reg);
         rdy = (rdy_mode < 0) ? 1'($urandom) : 1'(rdy_mode);
         fb  = (fb_mode < 0) ? 1'($urandom) : 1'(fb_mode);
         out_ready = rdy;
         feedback  = fb;
         tick();
         if (rdy) m_reg = shifted(m_reg, fb);
      end
      out_ready = 1'b0;
   endtask

   task automatic do_stop();
      stop      = 1'b1;
      out_ready = 1'b1;
      feedback  = 1'($urandom);
      tick();
      stop = 1'b0; out_ready = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_out_valid", out_valid, 0);
      chk("stop_taps_en", taps_en, 0);
      chk_static("stop");
   endtask

   initial begin
      logic [7:0] t_ok [NT];
      logic [7:0] t_bad [NT];
      logic [7:0] t_rnd [NT];
      logic [7:0] ks_exp;
      logic [SZ-1:0] s;

      for (int i = 0; i < NT; i++) t_ok[i] = 8'(i + 1);
      t_bad = t_ok;
      t_bad[2] = 8'h00;
      t_bad[8] = 8'h20;

      do_reset("reset");

      // Known keystream: seed LSB-first with zero feedback
      load_table(t_ok, 0, 0);
      do_seed(32'hDEADBEEF);
      start_run(0, 0);
      ks_exp = 8'b1110_1111;
      for (int c = 0; c < 8; c++) begin
         chk("ks_bit", out_bit, ks_exp[c]);
         chk("ks_reg", register, 32'hDEADBEEF >> c);
         out_ready = 1'b1;
         feedback  = 1'b0;
         tick();
         m_reg = shifted(m_reg, 0);
      end
      out_ready = 1'b0;
      do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_in_idle_busy", busy, 0);
      chk_static("stop_in_idle");

      // Bad tap table blocks start until a clean table is loaded
      load_table(t_bad, 2, 0);
      chk("bad_cfg_err", cfg_err, 1);
      chk("bad_rtr", ready_to_run, 0);
      start_run(3, -1);
      load_table(t_ok, 1, 1);
      chk("reload_cfg_err", cfg_err, 0);

      // Zero seed is rejected and blocks start
      do_seed('0);
      chk("zero_seed_err", seed_err, 1);
      start_run(4, -1);
      do_seed(32'h1);
      chk("one_seed_err", seed_err, 0);

      // seed_valid outranks start in the same cycle
      seed_valid = 1'b1; seed = 32'h1; start = 1'b1; warmup = 16'd2;
      tick();
      seed_valid = 1'b0; start = 1'b0;
      chk("seed_over_start_busy", busy, 0);

      // Five warm-up shifts of ones into seed 1
      start_run(5, 1);
      chk("warm5_reg", register, 32'hF8000000);

      // Backpressure holds the bit, then stop wins over the handshake
      stream(4, -1, 0);
      do_stop();
      start_run(2, -1);
      stream(20, -1, -1);
      do_stop();

      // Randomized sessions
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NT; i++) t_rnd[i] = 8'($urandom_range(SZ - 1, 1));
         load_table(t_rnd, 2, r[0]);
         do s = $urandom; while (s == '0);
         do_seed(s);
         start_run(int'($urandom_range(12)), -1);
         stream(30, -1, -1);
         do_stop();
      end

      // Reset mid-load after 7 bytes
      load_cfg = 1'b1;
      tick();
      load_cfg = 1'b0;
      for (int i = 0; i < 7; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = 8'(i + 3);
         tick();
      end
      cfg_valid = 1'b0;
      do_reset("reset_mid_load");

      // Reset mid-run
      load_table(t_ok, 0, 0);
      do_seed(32'hA5A5_0F0F);
      start_run(3, -1);
      stream(5, -1, -1);
      out_ready = 1'b1;
      do_reset("reset_mid_run");
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
